// File: rtl/spi_msg_sequencer_pkg.sv
// Shared constants and state encoding for the SPI message sequencer.
package spi_msg_sequencer_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int MSG_DEPTH  = 64;
  localparam int MSG_ADDR_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_REQ       = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_STORE     = 3'd5,
    ST_GAP       = 3'd6,
    ST_FINISH    = 3'd7
  } state_e;
endpackage

// File: rtl/spi_msg_sequencer_msg_dpram.sv
// 64x8 message buffer: one write port, one registered read port.
// Contents are not reset; only the read register clears on reset.
module msg_dpram
  import spi_msg_sequencer_pkg::*;
(
  input  logic                  I_CLK,
  input  logic                  I_RESETN,
  input  logic                  i_we,
  input  logic [MSG_ADDR_W-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [MSG_ADDR_W-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [MSG_DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Storage write; a same-address read this cycle still sees the old word.
  always_ff @(posedge I_CLK) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read, cleared by reset so the output is 0 until the first read.
  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) r_rdata <= '0;
    else           r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/spi_msg_sequencer.sv
// Message-level sequencer driving a byte-level SPI controller from a TX
// buffer and collecting replies into an RX buffer.
// Optional: SPI_SEQ_ZERO_TERM_EN stops the message at a 0x00 TX byte.
module spi_msg_sequencer
  import spi_msg_sequencer_pkg::*;
#(
  parameter int MSG_LEN     = 64,
  parameter int GAP_CYCLES  = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                  I_CLK,
  input  logic                  I_RESETN,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  tx_we,
  input  logic [MSG_ADDR_W-1:0] tx_waddr,
  input  logic [DATA_WIDTH-1:0] tx_wdata,
  input  logic [MSG_ADDR_W-1:0] rx_raddr,
  output logic [DATA_WIDTH-1:0] rx_rdata,
  output logic                  byte_req,
  output logic [DATA_WIDTH-1:0] byte_tx,
  input  logic                  byte_busy,
  input  logic [DATA_WIDTH-1:0] byte_rx,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [6:0]            rx_count
);
  localparam logic [MSG_ADDR_W-1:0] IDX_LAST = MSG_ADDR_W'(MSG_LEN - 1);
  localparam logic [6:0]            CNT_MAX  = 7'(MSG_LEN);
  localparam logic [7:0]            GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam logic [7:0]            TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_e                r_state, w_state_nxt;
  logic [MSG_ADDR_W-1:0] r_idx, w_idx_nxt;
  logic [6:0]            r_rx_count;
  logic [DATA_WIDTH-1:0] r_byte_tx;
  logic [7:0]            r_gap, r_tmo;
  logic                  r_error, r_abort_pend;
  logic [DATA_WIDTH-1:0] w_tx_rdata;
  logic                  w_last, w_tmo_hit, w_store;

  assign w_last    = (r_idx == IDX_LAST);
  assign w_tmo_hit = (r_state == ST_WAIT_ACK) && !byte_busy && (r_tmo == TMO_LAST);
  assign w_store   = (r_state == ST_STORE);

  // TX buffer is addressed with the next index so the word is ready in LOAD.
  msg_dpram u_tx_buf (
    .I_CLK   (I_CLK),
    .I_RESETN(I_RESETN),
    .i_we    (tx_we),
    .i_waddr (tx_waddr),
    .i_wdata (tx_wdata),
    .i_raddr (w_idx_nxt),
    .o_rdata (w_tx_rdata)
  );

  msg_dpram u_rx_buf (
    .I_CLK   (I_CLK),
    .I_RESETN(I_RESETN),
    .i_we    (w_store),
    .i_waddr (r_idx),
    .i_wdata (byte_rx),
    .i_raddr (rx_raddr),
    .o_rdata (rx_rdata)
  );

  // Next-state and next-index logic.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: if (start) begin
        w_state_nxt = ST_LOAD;
        w_idx_nxt   = '0;
      end
      ST_LOAD: begin
        if (abort) w_state_nxt = ST_FINISH;
`ifdef SPI_SEQ_ZERO_TERM_EN
        else if (w_tx_rdata == '0) w_state_nxt = ST_FINISH;
`endif
        else w_state_nxt = ST_REQ;
      end
      ST_REQ:  w_state_nxt = abort ? ST_FINISH : ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (byte_busy)               w_state_nxt = ST_WAIT_DONE;
        else if (abort || w_tmo_hit) w_state_nxt = ST_FINISH;
      end
      ST_WAIT_DONE: if (!byte_busy) w_state_nxt = ST_STORE;
      ST_STORE: begin
        if (w_last || abort || r_abort_pend) w_state_nxt = ST_FINISH;
        else if (GAP_CYCLES == 0) begin
          w_state_nxt = ST_LOAD;
          w_idx_nxt   = r_idx + 1'b1;
        end else w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (abort) w_state_nxt = ST_FINISH;
        else if (r_gap == GAP_LAST) begin
          w_state_nxt = ST_LOAD;
          w_idx_nxt   = r_idx + 1'b1;
        end
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State, index, counters, status and the held byte_tx register.
  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_rx_count   <= '0;
      r_byte_tx    <= '0;
      r_gap        <= '0;
      r_tmo        <= '0;
      r_error      <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_gap   <= (r_state == ST_GAP) ? r_gap + 1'b1 : '0;
      r_tmo   <= (r_state == ST_WAIT_ACK) ? r_tmo + 1'b1 : '0;
      if (r_state == ST_IDLE && start) begin
        r_rx_count   <= '0;
        r_error      <= 1'b0;
        r_abort_pend <= 1'b0;
      end
      if (r_state == ST_LOAD) r_byte_tx <= w_tx_rdata;
      if (w_tmo_hit) r_error <= 1'b1;
      // Abort seen mid-byte is remembered so STORE still completes first.
      if (r_state == ST_WAIT_DONE && abort) r_abort_pend <= 1'b1;
      if (w_store && r_rx_count != CNT_MAX) r_rx_count <= r_rx_count + 1'b1;
    end
  end

  assign byte_req = (r_state == ST_REQ);
  assign byte_tx  = r_byte_tx;
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_FINISH);
  assign error    = r_error;
  assign rx_count = r_rx_count;
endmodule

// File: tb/tb_spi_msg_sequencer.sv
// Directed bench: two sequencers (6-byte/gap 16 and 64-byte/gap 4) on
// shared clock, reset and TX write bus, each with a loopback byte controller.
module tb_spi_msg_sequencer;
  logic       clk = 1'b0, rstn = 1'b0;
  logic       tx_we = 1'b0, abort = 1'b0;
  logic [5:0] tx_waddr = '0;
  logic [7:0] tx_wdata = '0;

  logic       start_a = 0, start_b = 0, mute_a = 0;
  logic [5:0] rx_raddr_a = '0, rx_raddr_b = '0;
  logic [7:0] rx_rdata_a, rx_rdata_b, byte_tx_a, byte_tx_b, byte_rx_a, byte_rx_b;
  logic       byte_req_a, byte_req_b, byte_busy_a, byte_busy_b;
  logic       busy_a, busy_b, done_a, done_b, error_a, error_b;
  logic [6:0] rx_count_a, rx_count_b;

  int n_chk = 0, n_err = 0;
  int cyc = 0, req_a = 0, req_b = 0, fall_a = 0, gap_a = 0;
  logic bb_a_q = 1'b0;

  always #5 clk = ~clk;

  spi_msg_sequencer #(.MSG_LEN(6), .GAP_CYCLES(16), .ACK_TIMEOUT(255)) u_dut_a (
    .I_CLK(clk), .I_RESETN(rstn), .start(start_a), .abort(abort),
    .tx_we(tx_we), .tx_waddr(tx_waddr), .tx_wdata(tx_wdata),
    .rx_raddr(rx_raddr_a), .rx_rdata(rx_rdata_a),
    .byte_req(byte_req_a), .byte_tx(byte_tx_a), .byte_busy(byte_busy_a), .byte_rx(byte_rx_a),
    .busy(busy_a), .done(done_a), .error(error_a), .rx_count(rx_count_a));

  spi_msg_sequencer #(.MSG_LEN(64), .GAP_CYCLES(4), .ACK_TIMEOUT(255)) u_dut_b (
    .I_CLK(clk), .I_RESETN(rstn), .start(start_b), .abort(abort),
    .tx_we(tx_we), .tx_waddr(tx_waddr), .tx_wdata(tx_wdata),
    .rx_raddr(rx_raddr_b), .rx_rdata(rx_rdata_b),
    .byte_req(byte_req_b), .byte_tx(byte_tx_b), .byte_busy(byte_busy_b), .byte_rx(byte_rx_b),
    .busy(busy_b), .done(done_b), .error(error_b), .rx_count(rx_count_b));

  // Loopback byte controllers: 2 idle cycles after byte_req, then 4 busy cycles.
  logic [2:0] lb_cnt_a, lb_cnt_b;
  logic [7:0] lb_rx_a, lb_rx_b;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lb_cnt_a <= '0; lb_rx_a <= '0; lb_cnt_b <= '0; lb_rx_b <= '0;
    end else begin
      if (byte_req_a && !mute_a) begin lb_cnt_a <= 3'd6; lb_rx_a <= byte_tx_a; end
      else if (lb_cnt_a != 0) lb_cnt_a <= lb_cnt_a - 3'd1;
      if (byte_req_b) begin lb_cnt_b <= 3'd6; lb_rx_b <= byte_tx_b; end
      else if (lb_cnt_b != 0) lb_cnt_b <= lb_cnt_b - 3'd1;
    end
  end
  assign byte_busy_a = (lb_cnt_a != 0) && (lb_cnt_a <= 3'd4);
  assign byte_busy_b = (lb_cnt_b != 0) && (lb_cnt_b <= 3'd4);
  assign byte_rx_a   = lb_rx_a;
  assign byte_rx_b   = lb_rx_b;

  // Event monitor: request counts and distance from byte_busy fall to next request.
  always @(negedge clk) begin
    cyc    <= cyc + 1;
    bb_a_q <= byte_busy_a;
    if (bb_a_q && !byte_busy_a) fall_a <= cyc;
    if (byte_req_a) begin req_a <= req_a + 1; gap_a <= cyc - fall_a; end
    if (byte_req_b) req_b <= req_b + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  function automatic logic probe(input int w);
    case (w)
      0: return byte_req_a;
      1: return byte_busy_a;
      3: return done_a;
      4: return byte_req_b;
      5: return byte_busy_b;
      6: return !byte_busy_b;
      7: return done_b;
      8: return error_a;
      default: return 1'b1;
    endcase
  endfunction

  task automatic wait_for(input int w, input int maxc, input string tag, output int n);
    n = 0;
    while (!probe(w) && n < maxc) begin tick(); n++; end
    if (!probe(w)) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    tx_waddr = a; tx_wdata = d; tx_we = 1'b1; tick(); tx_we = 1'b0;
  endtask

  task automatic rd_a(input logic [5:0] a, output logic [7:0] d);
    rx_raddr_a = a; tick(); d = rx_rdata_a;
  endtask

  task automatic rd_b(input logic [5:0] a, output logic [7:0] d);
    rx_raddr_b = a; tick(); d = rx_rdata_b;
  endtask

  logic [7:0] msg [6] = '{8'h4D, 8'h41, 8'h53, 8'h54, 8'h45, 8'h52}; // "MASTER"

  initial begin
    int n, r0;
    logic [7:0] d;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_error", error_a, 0);
    chk("rst_rx_count", rx_count_a, 0);
    chk("rst_byte_req", byte_req_a, 0);
    chk("rst_byte_tx", byte_tx_a, 0);
    chk("rst_rx_rdata", rx_rdata_a, 0);
    rstn = 1'b1;
    tick();

    // TX buffer: "MASTER", 0x00, then nonzero filler
    for (int i = 0; i < 6; i++) wr(6'(i), msg[i]);
    wr(6'd6, 8'h00);
    for (int i = 7; i < 64; i++) wr(6'(i), 8'(i + 8'h20));

    // 6-byte loopback exchange
    r0 = req_a;
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_for(3, 2000, "a_done", n);
    chk("a_rx_count", rx_count_a, 6);
    chk("a_error", error_a, 0);
    chk("a_requests", req_a - r0, 6);
    // byte_busy fall cycle -> STORE + 16 gap + LOAD -> REQ
    chk("a_gap_to_req", gap_a, 19);
    tick();
    chk("a_done_pulse", done_a, 0);
    chk("a_busy_idle", busy_a, 0);
    for (int i = 0; i < 6; i++) begin
      rd_a(6'(i), d);
      chk($sformatf("a_rx_buf%0d", i), d, msg[i]);
    end

    // Abort during byte 3 WAIT_DONE
    wr(6'd3, 8'hA5);
    r0 = req_a;
    start_a = 1'b1; tick(); start_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_for(0, 200, "abort_req", n);
      if (k < 3) tick();
    end
    wait_for(1, 20, "abort_busy", n);
    tick();
    abort = 1'b1;
    wait_for(3, 50, "abort_done", n);
    abort = 1'b0;
    chk("abort_rx_count", rx_count_a, 4);
    repeat (40) tick();
    chk("abort_requests", req_a - r0, 4);
    rd_a(6'd3, d);
    chk("abort_rx_buf3", d, 8'hA5);
    rd_a(6'd4, d);
    chk("abort_rx_buf4_kept", d, 8'h45);
    wr(6'd3, 8'h54);

    // Acknowledge timeout: 255 wait cycles after the request cycle
    mute_a = 1'b1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_for(0, 20, "tmo_req", n);
    wait_for(8, 400, "tmo_error", n);
    chk("tmo_cycles", n, 256);
    chk("tmo_done", done_a, 1);
    tick();
    chk("tmo_busy", busy_a, 0);
    chk("tmo_error_sticky", error_a, 1);
    mute_a = 1'b0;

    // 64-byte message, optionally NUL-terminated
    r0 = req_b;
    start_b = 1'b1; tick(); start_b = 1'b0;
    wait_for(7, 3000, "b_done", n);
`ifdef SPI_SEQ_ZERO_TERM_EN
    chk("b_rx_count", rx_count_b, 6);
    chk("b_requests", req_b - r0, 6);
`else
    chk("b_rx_count", rx_count_b, 64);
    chk("b_requests", req_b - r0, 64);
    rd_b(6'd6, d);
    chk("b_rx_buf6_nul", d, 8'h00);
    rd_b(6'd63, d);
    chk("b_rx_buf63", d, 8'h5F);
`endif
    rd_b(6'd5, d);
    chk("b_rx_buf5", d, 8'h52);

    // Reset during GAP of byte 10 (only possible without early termination)
`ifndef SPI_SEQ_ZERO_TERM_EN
    tick();
    r0 = req_b;
    start_b = 1'b1; tick(); start_b = 1'b0;
    for (int k = 0; k < 11; k++) begin
      wait_for(4, 100, "rst_mid_req", n);
      if (k < 10) tick();
    end
    wait_for(5, 20, "rst_mid_busy", n);
    wait_for(6, 20, "rst_mid_fall", n);
    tick(); tick();
    chk("rst_mid_in_gap", busy_b, 1);
    rstn = 1'b0;
    #1;
    chk("rst_mid_busy", busy_b, 0);
    chk("rst_mid_req", byte_req_b, 0);
    chk("rst_mid_done", done_b, 0);
    chk("rst_mid_rx_count", rx_count_b, 0);
    chk("rst_mid_byte_tx", byte_tx_b, 0);
    tick(); tick();
    rstn = 1'b1;
    repeat (40) tick();
    chk("rst_mid_no_req", req_b - r0, 11);
    chk("rst_mid_idle", busy_b, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
